// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP multi-cycle control unit.
package bip_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110,
    OP_HLT  = 5'b11111
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    SELA_RAM  = 2'b00,
    SELA_OPND = 2'b01,
    SELA_ALU  = 2'b10
  } sela_e;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  // Opcodes that wait on the RAM handshake in EXEC
  function automatic logic is_mem_op(opcode_e op);
    return (op == OP_STO) || (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bip_ctrl_unit_if.sv
// Control-unit <-> ROM/PC/datapath signal bundle.
// With BIP_CTRL_PERF_EN defined, the bundle also carries the performance counters.
interface bip_ctrl_unit_if #(
  parameter int unsigned OPC_W = 5
);

  logic [OPC_W-1:0] opcode_i;
  logic             instr_valid_i;
  logic             mem_ready_i;
  logic             z_i;
  logic             n_i;
  logic             enrom_o;
  logic             wrpc_o;
  logic             branch_o;
  logic [1:0]       sela_o;
  logic             selb_o;
  logic             op_o;
  logic             wracc_o;
  logic             enram_o;
  logic             wrram_o;
  logic             halt_o;
  logic             trap_o;
`ifdef BIP_CTRL_PERF_EN
  logic [31:0]      retired_o;
  logic [31:0]      stall_o;
`endif

  // Control unit side
  modport master (
    input  opcode_i, instr_valid_i, mem_ready_i, z_i, n_i,
    output enrom_o, wrpc_o, branch_o, sela_o, selb_o, op_o,
    output wracc_o, enram_o, wrram_o, halt_o,
`ifdef BIP_CTRL_PERF_EN
    output retired_o, output stall_o,
`endif
    output trap_o
  );

  // ROM / PC / datapath side
  modport slave (
    output opcode_i, instr_valid_i, mem_ready_i, z_i, n_i,
    input  enrom_o, wrpc_o, branch_o, sela_o, selb_o, op_o,
    input  wracc_o, enram_o, wrram_o, halt_o,
`ifdef BIP_CTRL_PERF_EN
    input  retired_o, input stall_o,
`endif
    input  trap_o
  );

endinterface

// File: rtl/bip_branch_cond.sv
// Branch condition evaluation: opcode plus ALU flags -> branch taken.
module bip_branch_cond
  import bip_pkg::*;
(
  input  opcode_e i_opcode,
  input  logic    i_z,
  input  logic    i_n,
  output logic    o_taken
);

  // Non-branch opcodes never report taken
  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BEQ:  o_taken = i_z;
      OP_BNE:  o_taken = !i_z;
      OP_BGT:  o_taken = !i_z && !i_n;
      OP_BGE:  o_taken = !i_n;
      OP_BLT:  o_taken = i_n;
      OP_BLE:  o_taken = i_z || i_n;
      OP_JMP:  o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip_ctrl_unit.sv
// BIP multi-cycle control unit: FETCH/EXEC sequencing with ROM/RAM handshakes,
// branches, halt and a sticky trap for illegal opcodes or RAM timeouts.
// Optional BIP_CTRL_PERF_EN adds retired/stall counters on the interface.
module bip_ctrl_unit
  import bip_pkg::*;
#(
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  bip_ctrl_unit_if.master bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [OPC_W-1:0]   r_opc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  opcode_e            w_opc;
  logic               w_legal;
  logic               w_taken;
  logic               w_mem_wait;
  logic               w_enrom;
  logic               w_wrpc;
  logic               w_branch;
  sela_e              w_sela;
  logic               w_selb;
  logic               w_op;
  logic               w_wracc;
  logic               w_enram;
  logic               w_wrram;

  assign w_opc   = opcode_e'(r_opc[4:0]);
  // Legal only if nothing is set above bit 4 and the low field is a defined opcode
  assign w_legal = ((r_opc >> 5) == '0) &&
                   ((r_opc[4:0] <= 5'b01110) || (r_opc[4:0] == 5'b11111));

  bip_branch_cond u_branch_cond (
    .i_opcode (w_opc),
    .i_z      (bus.z_i),
    .i_n      (bus.n_i),
    .o_taken  (w_taken)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= FETCH;
    else         r_state <= w_state_nxt;
  end

  // Opcode latch on the ROM handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   r_opc <= OPC_W'(OP_NOP);
    else if (r_state == FETCH && bus.instr_valid_i) r_opc <= bus.opcode_i;
  end

  // RAM wait counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end

  // Next state and decoded strobes/mux selects
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_mem_wait  = 1'b0;
    w_enrom     = 1'b0;
    w_wrpc      = 1'b0;
    w_branch    = 1'b0;
    w_sela      = SELA_RAM;
    w_selb      = 1'b0;
    w_op        = ALU_SUB;
    w_wracc     = 1'b0;
    w_enram     = 1'b0;
    w_wrram     = 1'b0;
    case (r_state)
      FETCH: begin
        w_enrom = 1'b1;
        if (bus.instr_valid_i) w_state_nxt = EXEC;
      end
      EXEC: begin
        if (!w_legal) begin
          w_state_nxt = TRAP;
        end else if (is_mem_op(w_opc)) begin
          w_enram = 1'b1;
          w_wrram = (w_opc == OP_STO);
          case (w_opc)
            OP_ADD: begin w_sela = SELA_ALU; w_op = ALU_ADD; end
            OP_SUB: begin w_sela = SELA_ALU; w_op = ALU_SUB; end
            default: w_sela = SELA_RAM;
          endcase
          // Ready is checked before the timeout so a late ready still completes
          if (bus.mem_ready_i) begin
            w_wrpc      = 1'b1;
            w_wracc     = (w_opc != OP_STO);
            w_state_nxt = FETCH;
          end else begin
            w_mem_wait = 1'b1;
            if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) w_state_nxt = TRAP;
            else                                  w_cnt_nxt   = r_cnt + 1'b1;
          end
        end else if (w_opc == OP_HLT) begin
          w_state_nxt = HALT;
        end else begin
          w_wrpc      = 1'b1;
          w_branch    = w_taken;
          w_state_nxt = FETCH;
          case (w_opc)
            OP_LDI:  begin w_sela = SELA_OPND; w_selb = 1'b1; w_wracc = 1'b1; end
            OP_ADDI: begin w_sela = SELA_ALU; w_selb = 1'b1; w_op = ALU_ADD; w_wracc = 1'b1; end
            OP_SUBI: begin w_sela = SELA_ALU; w_selb = 1'b1; w_op = ALU_SUB; w_wracc = 1'b1; end
            default: w_sela = SELA_RAM;
          endcase
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign bus.enrom_o  = w_enrom;
  assign bus.wrpc_o   = w_wrpc;
  assign bus.branch_o = w_branch;
  assign bus.sela_o   = w_sela;
  assign bus.selb_o   = w_selb;
  assign bus.op_o     = w_op;
  assign bus.wracc_o  = w_wracc;
  assign bus.enram_o  = w_enram;
  assign bus.wrram_o  = w_wrram;
  assign bus.halt_o   = (r_state == HALT);
  assign bus.trap_o   = (r_state == TRAP);

`ifdef BIP_CTRL_PERF_EN
  logic [31:0] r_retired;
  logic [31:0] r_stall;

  // Retired-instruction and stall-cycle counters, free-running with wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_retired <= '0;
      r_stall   <= '0;
    end else begin
      if (w_wrpc) r_retired <= r_retired + 32'd1;
      if ((r_state == FETCH && !bus.instr_valid_i) || w_mem_wait) r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.retired_o = r_retired;
  assign bus.stall_o   = r_stall;
`endif

endmodule

// File: tb/tb_bip_ctrl_unit.sv
// Scoreboard bench for bip_ctrl_unit: a driver issues instructions and pushes the
// expected per-instruction response; a monitor pops it on each wrpc_o pulse.
module tb_bip_ctrl_unit;

  localparam int OPC_W = 6;
  localparam int TMO   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bip_ctrl_unit_if #(.OPC_W(OPC_W)) bus ();

  bip_ctrl_unit #(.OPC_W(OPC_W), .MEM_TIMEOUT(TMO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int         opc;
    int         cycles;
    int         enrom;
    int         enram;
    int         wrram;
    int         wracc;
    bit         branch;
    bit         chk_sela;
    bit         chk_selb;
    bit         chk_op;
    logic [1:0] sela;
    bit         selb;
    bit         alu_op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_mem(int opc);
    return opc == 1 || opc == 2 || opc == 4 || opc == 6;
  endfunction

  // Reference: what one instruction should look like from the outside
  function automatic exp_t model(int opc, int d, int w, bit z, bit n);
    exp_t e;
    e.opc      = opc;
    e.enrom    = d + 1;
    e.enram    = is_mem(opc) ? w + 1 : 0;
    e.wrram    = (opc == 1) ? w + 1 : 0;
    e.cycles   = d + 1 + (is_mem(opc) ? w + 1 : 1);
    e.wracc    = (opc >= 2 && opc <= 7) ? 1 : 0;
    case (opc)
      8:  e.branch = z;
      9:  e.branch = !z;
      10: e.branch = !z && !n;
      11: e.branch = !n;
      12: e.branch = n;
      13: e.branch = z || n;
      14: e.branch = 1'b1;
      default: e.branch = 1'b0;
    endcase
    e.chk_sela = (opc >= 2 && opc <= 7);
    e.chk_selb = (opc >= 3 && opc <= 7);
    e.chk_op   = (opc >= 4 && opc <= 7);
    e.sela     = (opc == 2) ? 2'b00 : (opc == 3) ? 2'b01 : 2'b10;
    e.selb     = (opc == 3 || opc == 5 || opc == 7);
    e.alu_op   = (opc == 4 || opc == 5);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_only(input int opc);
    bus.opcode_i      = OPC_W'(opc);
    bus.instr_valid_i = 1'b1;
    bus.mem_ready_i   = 1'b0;
    cyc();
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic issue(input int opc, input int d, input int w, input bit z, input bit n);
    sb.push_back(model(opc, d, w, z, n));
    bus.instr_valid_i = 1'b0;
    repeat (d) begin
      bus.opcode_i    = OPC_W'($urandom);
      bus.mem_ready_i = 1'($urandom);
      bus.z_i         = 1'($urandom);
      bus.n_i         = 1'($urandom);
      cyc();
    end
    bus.opcode_i      = OPC_W'(opc);
    bus.instr_valid_i = 1'b1;
    bus.mem_ready_i   = 1'($urandom);
    cyc();
    bus.instr_valid_i = 1'b0;
    bus.opcode_i      = OPC_W'($urandom);
    bus.z_i           = z;
    bus.n_i           = n;
    if (is_mem(opc)) begin
      bus.mem_ready_i = 1'b0;
      repeat (w) cyc();
      bus.mem_ready_i = 1'b1;
      cyc();
      bus.mem_ready_i = 1'b0;
    end else begin
      bus.mem_ready_i = 1'($urandom);
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.mem_ready_i   = 1'b0;
    sb.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Monitor: accumulate per-instruction activity, compare on each PC strobe
  initial begin
    int   n_cyc, n_rom, n_ram, n_wr, n_acc;
    exp_t e;
    n_cyc = 0; n_rom = 0; n_ram = 0; n_wr = 0; n_acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_cyc = 0; n_rom = 0; n_ram = 0; n_wr = 0; n_acc = 0;
      end else begin
        n_cyc++;
        n_rom += int'(bus.enrom_o);
        n_ram += int'(bus.enram_o);
        n_wr  += int'(bus.wrram_o);
        n_acc += int'(bus.wracc_o);
        if (bus.wrpc_o === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wrpc: got wrpc_o=1, expected 0 with no instruction pending");
          end else begin
            e = sb.pop_front();
            check($sformatf("latency op%0d", e.opc), n_cyc, e.cycles);
            check($sformatf("enrom_cycles op%0d", e.opc), n_rom, e.enrom);
            check($sformatf("enram_cycles op%0d", e.opc), n_ram, e.enram);
            check($sformatf("wrram_cycles op%0d", e.opc), n_wr, e.wrram);
            check($sformatf("wracc_pulses op%0d", e.opc), n_acc, e.wracc);
            check($sformatf("wracc_at_wrpc op%0d", e.opc), bus.wracc_o, e.wracc);
            check($sformatf("branch op%0d", e.opc), bus.branch_o, e.branch);
            if (e.chk_sela) check($sformatf("sela op%0d", e.opc), bus.sela_o, e.sela);
            if (e.chk_selb) check($sformatf("selb op%0d", e.opc), bus.selb_o, e.selb);
            if (e.chk_op)   check($sformatf("alu_op op%0d", e.opc), bus.op_o, e.alu_op);
          end
          n_cyc = 0; n_rom = 0; n_ram = 0; n_wr = 0; n_acc = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of stimulus, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    bit ok;
    int opc, d, w;
    bus.opcode_i      = '0;
    bus.instr_valid_i = 1'b0;
    bus.mem_ready_i   = 1'b0;
    bus.z_i           = 1'b0;
    bus.n_i           = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    check("rst_enrom",  bus.enrom_o,  1);
    check("rst_wrpc",   bus.wrpc_o,   0);
    check("rst_wracc",  bus.wracc_o,  0);
    check("rst_enram",  bus.enram_o,  0);
    check("rst_wrram",  bus.wrram_o,  0);
    check("rst_branch", bus.branch_o, 0);
    check("rst_sela",   bus.sela_o,   0);
    check("rst_halt",   bus.halt_o,   0);
    check("rst_trap",   bus.trap_o,   0);
    cyc();
    rst_n = 1'b1;

    // Back-to-back immediates, then RAM and branch cases
    issue(3, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0);
    issue(7, 0, 0, 1, 0);
    issue(2, 0, 3, 0, 0);
    issue(2, 1, TMO - 1, 0, 0);
    issue(1, 0, 2, 0, 0);
    issue(8, 0, 0, 1, 0);
    issue(8, 0, 0, 0, 0);
    issue(13, 0, 0, 0, 1);
    issue(14, 2, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      opc = $urandom_range(0, 14);
      d   = $urandom_range(0, 3);
      w   = ($urandom_range(0, 9) == 0) ? $urandom_range(6, TMO - 1) : $urandom_range(0, 5);
      issue(opc, d, w, 1'($urandom), 1'($urandom));
    end
    check("sb_drained", sb.size(), 0);

    // STO that never gets ready: trap after TMO exec cycles
    fetch_only(1);
    ok = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      ok &= (bus.trap_o == 1'b0) && bus.enram_o && bus.wrram_o && !bus.wrpc_o;
      cyc();
    end
    check("tmo_wait_phase", ok, 1);
    @(negedge clk);
    check("tmo_trap", bus.trap_o, 1);
    check("tmo_enram_off", bus.enram_o, 0);
    check("tmo_enrom_off", bus.enrom_o, 0);
    ok = 1'b1;
    repeat (10) begin
      bus.instr_valid_i = 1'b1;
      cyc();
      @(negedge clk);
      ok &= bus.trap_o && !bus.enrom_o && !bus.wrpc_o;
    end
    cyc();
    check("tmo_trap_sticky", ok, 1);
    do_reset();
    @(negedge clk);
    check("trap_cleared", bus.trap_o, 0);
    cyc();
    do_reset();

    // Illegal opcodes: undefined low field, and a defined one with an upper bit set
    fetch_only(6'b010000);
    @(negedge clk);
    check("ill_exec_strobes", {bus.wrpc_o, bus.wracc_o, bus.enram_o}, 0);
    cyc();
    @(negedge clk);
    check("ill_trap", bus.trap_o, 1);
    check("ill_enrom", bus.enrom_o, 0);
    cyc();
    do_reset();
    fetch_only(6'b100001);
    cyc();
    @(negedge clk);
    check("ill_hibit_trap", bus.trap_o, 1);
    cyc();
    do_reset();

    // Reset in the middle of a LD wait
    fetch_only(2);
    repeat (2) cyc();
    #2;
    rst_n           = 1'b0;
    bus.mem_ready_i = 1'b1;
    #1;
    check("midrst_enram", bus.enram_o, 0);
    check("midrst_enrom", bus.enrom_o, 1);
    check("midrst_wracc", bus.wracc_o, 0);
    check("midrst_wrpc",  bus.wrpc_o,  0);
    cyc();
    cyc();
    rst_n = 1'b1;
    issue(3, 0, 0, 0, 0);
    issue(4, 1, 1, 0, 0);

    // HLT: frozen until reset
    fetch_only(31);
    cyc();
    @(negedge clk);
    check("hlt_halt", bus.halt_o, 1);
    check("hlt_enrom", bus.enrom_o, 0);
    ok = 1'b1;
    repeat (50) begin
      bus.instr_valid_i = 1'b1;
      bus.opcode_i      = OPC_W'($urandom_range(0, 14));
      bus.mem_ready_i   = 1'($urandom);
      cyc();
      @(negedge clk);
      ok &= bus.halt_o && !bus.enrom_o && !bus.wrpc_o && !bus.wracc_o &&
            !bus.enram_o && !bus.wrram_o && !bus.branch_o;
    end
    check("hlt_hold_50", ok, 1);
    cyc();
    check("sb_final", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
